// File: rtl/out_uart_tx.sv
// -----------------------------------------------------------------------------
// out_uart_tx
//
// Output-port serialiser for the nic8 CPU. Watches the CPU output register
// `qreg` and, whenever its sampled value changes, queues the new value and
// sends it as three ASCII decimal digits plus a newline ("%03d\n") on an
// 8N1 UART line. A small FIFO absorbs bursts of output writes that arrive
// faster than the line can drain them.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit period (>= 2)
//   FIFO_DEPTH    pending values buffered (power of 2, >= 2)
//
// Ports:
//   clk       in   system clock, all state updates on posedge
//   reset     in   asynchronous, active-high reset
//   qreg      in   [7:0] CPU output register, sampled every posedge
//   tx        out  UART serial line, idle high (registered)
//   busy      out  FIFO non-empty or a value being converted/sent (registered)
//   overflow  out  sticky; a changed value was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module out_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] qreg,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StSend
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e            state_q, state_d;

    logic [7:0]        last_q_q, last_q_d;   // previous qreg sample
    logic              overflow_q, overflow_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;

    // Conversion datapath: v is the remainder, h/t/u the decimal digits.
    logic [7:0]        v_q, v_d;
    logic [1:0]        h_q, h_d;
    logic [3:0]        t_q, t_d;
    logic [3:0]        u_q, u_d;

    // Serialiser counters.
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;         // 0 start, 1..8 data, 9 stop
    logic [1:0]        chr_q, chr_d;         // character index within the value

    logic              tx_q, tx_d;
    logic              busy_q, busy_d;

    logic              change;
    logic              push;
    logic              pop;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            last_q_q   <= 8'd0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            v_q        <= 8'd0;
            h_q        <= 2'd0;
            t_q        <= 4'd0;
            u_q        <= 4'd0;
            baud_q     <= '0;
            bit_q      <= 4'd0;
            chr_q      <= 2'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q_q   <= last_q_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            v_q        <= v_d;
            h_q        <= h_d;
            t_q        <= t_d;
            u_q        <= u_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            chr_q      <= chr_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    // FIFO storage needs no reset: only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= qreg;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_q_d   = last_q_q;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        v_d        = v_q;
        h_d        = h_q;
        t_d        = t_q;
        u_d        = u_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        chr_d      = chr_q;

        // Change detect. Fullness is judged on the pre-pop count, so a push
        // into a full FIFO is dropped even when a pop happens on this edge.
        change = (qreg != last_q_q);
        push   = change && (count_q < CntFull);
        pop    = (state_q == StIdle) && (count_q != '0);

        if (change) begin
            last_q_d = qreg;
            if (!push) begin
                overflow_d = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(push) - CntW'(pop);

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    v_d     = mem_q[rd_ptr_q];
                    h_d     = 2'd0;
                    t_d     = 4'd0;
                    state_d = StConv;
                end
            end

            // Repeated subtraction, one step per cycle: hundreds first, then
            // tens; the remainder is the units digit.
            StConv: begin
                if (v_q >= 8'd100) begin
                    v_d = v_q - 8'd100;
                    h_d = h_q + 2'd1;
                end else if (v_q >= 8'd10) begin
                    v_d = v_q - 8'd10;
                    t_d = t_q + 4'd1;
                end else begin
                    u_d     = v_q[3:0];
                    chr_d   = 2'd0;
                    bit_d   = 4'd0;
                    baud_d  = '0;
                    state_d = StSend;
                end
            end

            // Four frames back to back; leave after the last stop bit.
            StSend: begin
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        bit_d = 4'd0;
                        if (chr_q == 2'd3) begin
                            state_d = StIdle;
                        end else begin
                            chr_d = chr_q + 2'd1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // Outputs are registered from the next-state values so that tx and busy
    // line up exactly with the state they describe and never glitch.
    // -------------------------------------------------------------------------
    logic [7:0] char_c;
    logic       frame_bit;

    always_comb begin
        char_c    = 8'h0A;
        frame_bit = 1'b1;

        unique case (chr_d)
            2'd0:    char_c = 8'h30 + {6'd0, h_d};
            2'd1:    char_c = 8'h30 + {4'd0, t_d};
            2'd2:    char_c = 8'h30 + {4'd0, u_d};
            2'd3:    char_c = 8'h0A;
            default: char_c = 8'h0A;
        endcase

        if (bit_d == 4'd0) begin
            frame_bit = 1'b0;
        end else if (bit_d <= 4'd8) begin
            frame_bit = char_c[3'(bit_d - 4'd1)];
        end else begin
            frame_bit = 1'b1;
        end

        tx_d   = (state_d == StSend) ? frame_bit : 1'b1;
        busy_d = (state_d != StIdle) || (count_d != '0);
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_out_uart_tx
//
// Scoreboard bench for out_uart_tx. The driver changes qreg and feeds each
// change to a reference model that works in whole values and edge numbers:
// it decides accept/drop from FIFO occupancy, computes when each value is
// popped, how long the decimal conversion takes and when each character's
// start bit must appear, and pushes the expected characters into a queue.
// A separate monitor decodes the tx line, pops and compares, and checks busy
// and overflow every cycle.
// -----------------------------------------------------------------------------
module tb_out_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] qreg = 8'd0;
    logic       tx;
    logic       busy;
    logic       overflow;

    out_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .qreg    (qreg),
        .tx      (tx),
        .busy    (busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Edge counter: after the k-th posedge, edge_n == k.
    int edge_n = 0;
    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d, required %0d", name, edge_n, act, req);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct {
        int push_e;
        int pop_e;
        int done_e;
    } ent_t;

    typedef struct {
        int ch;
        int start;
    } exp_t;

    ent_t acc[$];          // accepted values
    exp_t exp_q[$];        // expected characters, in line order
    int   m_last       = 0;
    int   m_free       = 0; // first edge at which the next pop may happen
    bit   m_ovf        = 1'b0;
    int   m_ovf_edge   = 0;
    int   m_last_start = 0;

    // qreg takes value v and is first sampled at edge e.
    task automatic model_change(input int e, input int v);
        int   cnt;
        int   pop_e;
        int   h, t, u, start;
        int   chars[4];
        ent_t en;
        exp_t ex;
        if (v == m_last) return;
        m_last = v;
        cnt = 0;
        foreach (acc[i]) if (acc[i].pop_e >= e) cnt++;
        if (cnt >= DEPTH) begin
            if (!m_ovf) begin
                m_ovf      = 1'b1;
                m_ovf_edge = e;
            end
            return;
        end
        pop_e = (e + 1 > m_free) ? e + 1 : m_free;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        // Conversion takes h+t+1 cycles after the pop; the last one starts tx.
        start = pop_e + 1 + h + t;
        chars[0] = 48 + h;
        chars[1] = 48 + t;
        chars[2] = 48 + u;
        chars[3] = 10;
        for (int k = 0; k < 4; k++) begin
            ex.ch    = chars[k];
            ex.start = start + k * FRAME;
            exp_q.push_back(ex);
        end
        en.push_e = e;
        en.pop_e  = pop_e;
        en.done_e = start + 4 * FRAME;
        acc.push_back(en);
        m_free       = en.done_e + 1;
        m_last_start = start;
    endtask

    task automatic model_reset();
        acc.delete();
        exp_q.delete();
        m_last = 0;
        m_free = 0;
        m_ovf  = 1'b0;
    endtask

    function automatic int exp_busy(input int k);
        foreach (acc[i]) if (acc[i].push_e <= k && k < acc[i].done_e) return 1;
        return 0;
    endfunction

    function automatic int exp_ovf(input int k);
        return (m_ovf && m_ovf_edge <= k) ? 1 : 0;
    endfunction

    // -------------------------------------------------------------------------
    // Monitor: UART decoder plus per-cycle busy/overflow checks
    // -------------------------------------------------------------------------
    initial begin
        bit         in_frame = 1'b0;
        int         f_start = 0;
        bit         f_bad = 1'b0;
        logic       f_val = 1'b1;
        logic [7:0] f_data = 8'd0;
        int         off, b, ph;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_frame = 1'b0;
                continue;
            end
            chk("busy", int'(busy), exp_busy(edge_n));
            chk("overflow", int'(overflow), exp_ovf(edge_n));
            if (!in_frame && tx == 1'b0) begin
                in_frame = 1'b1;
                f_start  = edge_n;
                f_bad    = 1'b0;
            end
            if (in_frame) begin
                off = edge_n - f_start;
                b   = off / CPB;
                ph  = off % CPB;
                if (ph == 0) begin
                    f_val = tx;
                    if (b >= 1 && b <= 8) f_data[b-1] = tx;
                    if (b == 0 && tx !== 1'b0) f_bad = 1'b1;
                    if (b == 9 && tx !== 1'b1) f_bad = 1'b1;
                end else if (tx !== f_val) begin
                    f_bad = 1'b1;
                end
                if (off == FRAME - 1) begin
                    in_frame = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_frame: got char %0d starting at edge %0d, required no frame",
                                 f_data, f_start);
                    end else begin
                        e = exp_q.pop_front();
                        chk("char", int'(f_data), e.ch);
                        chk("start_edge", f_start, e.start);
                        chk("framing_ok", int'(!f_bad), 1);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver
    // -------------------------------------------------------------------------
    task automatic drive(input int v);
        @(posedge clk);
        #1;
        qreg = 8'(v);
        model_change(edge_n + 1, v);
    endtask

    // Wait until the model says everything queued has left the line.
    task automatic wait_idle();
        while (edge_n < m_free + 2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        qreg  = 8'd0;
        model_reset();
        #1;
        chk("reset_tx", int'(tx), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_overflow", int'(overflow), 0);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        int v, gap, vmid;

        // Reset state, then a long quiet stretch with qreg = 0.
        #1;
        reset = 1'b1;
        #2;
        chk("init_tx", int'(tx), 1);
        chk("init_busy", int'(busy), 0);
        chk("init_overflow", int'(overflow), 0);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        repeat (1000) @(posedge clk);

        // Single value with the longest conversion.
        drive(255);
        wait_idle();

        // Small values and digit boundaries.
        drive(7);
        wait_idle();
        drive(100);
        wait_idle();
        drive(10);
        wait_idle();

        // Burst on consecutive edges: one popped, four buffered, one dropped.
        for (int i = 1; i <= 6; i++) drive(i);
        wait_idle();

        // Held value with a between-edge glitch that must stay invisible.
        drive(42);
        repeat (200) @(posedge clk);
        #2;
        qreg = 8'd99;
        #4;
        qreg = 8'd42;
        repeat (4800) @(posedge clk);
        wait_idle();

        // Random values with a mix of long gaps and short bursts.
        for (int i = 0; i < 30; i++) begin
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : $urandom_range(50, 900);
            repeat (gap - 1) @(posedge clk);
            v = $urandom_range(0, 255);
            drive(v);
        end
        wait_idle();

        // Reset during the 2nd character's data bits.
        vmid = (m_last == 77) ? 78 : 77;
        drive(vmid);
        while (edge_n < m_last_start + FRAME + 3 * CPB) @(posedge clk);
        do_reset();
        repeat (1000) @(posedge clk);
        drive(33);
        wait_idle();

        repeat (20) @(posedge clk);
        chk("frames_outstanding", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
